// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers PC-tagged instructions in an in-order prefetch FIFO toward decode.
module fetch_unit #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [15:0] RESET_PC        = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_err
);
  localparam int unsigned XLEN = 16;
  localparam int unsigned FPW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TPW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SUMW = ((FCW > OCW) ? FCW : OCW) + 1;

  typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

  state_t state, state_next;

  logic [XLEN-1:0] fetch_pc;
  logic [OCW-1:0]  outstanding;
  logic [OCW-1:0]  discard_cnt;

  logic [MAX_OUTSTANDING-1:0][XLEN-1:0] tag_q;
  logic [TPW-1:0] tag_wr, tag_rd;

  logic [FIFO_DEPTH-1:0][XLEN-1:0] fifo_pc;
  logic [FIFO_DEPTH-1:0][XLEN-1:0] fifo_data;
  logic [FPW-1:0] rd_ptr, wr_ptr;
  logic [FCW-1:0] fifo_count;

  logic [SUMW-1:0] credit_used;
  logic grant, rsp_ok, rsp_err, push, pop;

  function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // Next state and issue decision; credits cover FIFO slots already promised to in-flight words
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (halt) state_next = HALTED;
      HALTED:  if (!halt) state_next = FETCH;
      default: state_next = BOOT;
    endcase
    imem_req = (state == FETCH) && !halt && !redirect
               && (outstanding < OCW'(MAX_OUTSTANDING))
               && (credit_used < SUMW'(FIFO_DEPTH));
  end

  assign credit_used = SUMW'(fifo_count) + SUMW'(outstanding);
  assign grant       = imem_req && imem_gnt;
  assign rsp_ok      = imem_rvalid && (outstanding != '0);
  assign rsp_err     = imem_rvalid && (outstanding == '0);
  assign push        = rsp_ok && (discard_cnt == '0) && !redirect;
  assign pop         = inst_valid && inst_ready && !redirect;

  assign imem_addr  = fetch_pc;
  assign inst_valid = (fifo_count != '0);
  assign inst_data  = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // PC, in-flight accounting, tag queue and redirect bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      tag_q       <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fetch_err   <= 1'b0;
    end else begin
      if (rsp_err) fetch_err <= 1'b1;
      case ({grant, rsp_ok})
        2'b10:   outstanding <= outstanding + OCW'(1);
        2'b01:   outstanding <= outstanding - OCW'(1);
        default: ;
      endcase
      if (grant) begin
        tag_q[tag_wr] <= fetch_pc;
        tag_wr        <= tag_inc(tag_wr);
      end
      // Tags retire on every answered request, dropped or not, to stay aligned with memory order
      if (rsp_ok) tag_rd <= tag_inc(tag_rd);
      if (redirect) begin
        fetch_pc    <= redirect_pc;
        discard_cnt <= outstanding - OCW'(rsp_ok);
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(1);
        if (rsp_ok && (discard_cnt != '0)) discard_cnt <= discard_cnt - OCW'(1);
      end
    end
  end

  // Prefetch FIFO; redirect flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_pc    <= '0;
      fifo_data  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= tag_q[tag_rd];
        fifo_data[wr_ptr] <= imem_rdata;
        wr_ptr            <= wr_ptr + FPW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FPW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a program-order reference
// (consecutive PCs from the last redirect target, instr = pc ^ 16'hA5A5).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        fetch_err;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          gcount = 0;
  int          delivered = 0;
  logic [15:0] exp_pc = '0;
  logic [15:0] last_pc = '0;
  int unsigned gnt_pct = 100;
  int unsigned rdy_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic        spurious = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_addr",  32'(imem_addr),  32'h0000);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data",  32'(inst_data),  32'h0000);
    chk("rst_pc",    32'(inst_pc),    32'h0000);
    chk("rst_err",   32'(fetch_err),  32'd0);
  endtask

  // One clock: drive memory/decode at negedge, score at +1, advance to next negedge
  task automatic cycle();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (spurious) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hDEAD;
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr ^ 16'hA5A5;
    end
    imem_gnt   = ($urandom_range(99, 0) < gnt_pct);
    inst_ready = ($urandom_range(99, 0) < rdy_pct);
    #1;
    if (inst_valid && inst_ready && !redirect) begin
      chk("deliver_pc",   32'(inst_pc),   32'(exp_pc));
      chk("deliver_data", 32'(inst_data), 32'(exp_pc ^ 16'hA5A5));
      last_pc = inst_pc;
      exp_pc  = exp_pc + 16'd1;
      delivered++;
    end
    if (redirect) exp_pc = redirect_pc;
    if (redirect || halt) chk("req_off", 32'(imem_req), 32'd0);
    if (imem_req && imem_gnt) begin
      mq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      gcount++;
    end
    if (imem_rvalid && !spurious) void'(mq.pop_front());
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    spurious = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; halt = 1'b0; spurious = 1'b0;
    mq.delete();
    exp_pc = '0;
    gcount = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst_n = 1'b1;
  endtask

  initial begin
    int          d0;
    logic        ok;
    logic [15:0] held;

    // Reset / boot: first request at 0 one cycle after BOOT, stream 0..3
    do_reset();
    chk("boot_noreq", 32'(imem_req), 32'd0);
    cycle();
    chk("boot_req",  32'(imem_req),  32'd1);
    chk("boot_addr", 32'(imem_addr), 32'h0000);
    repeat (12) cycle();
    chk("boot_stream", 32'(delivered >= 4), 32'd1);

    // Backpressure: exactly four buffered, no further requests
    do_reset();
    rdy_pct = 0;
    repeat (12) cycle();
    chk("bp_grants", 32'(gcount),     32'd4);
    chk("bp_valid",  32'(inst_valid), 32'd1);
    chk("bp_noreq",  32'(imem_req),   32'd0);
    chk("bp_headpc", 32'(inst_pc),    32'h0000);
    d0 = delivered;
    rdy_pct = 100;
    repeat (20) cycle();
    chk("bp_resume", 32'(delivered >= d0 + 8), 32'd1);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      if (mq.size() == 2) ok = 1'b1;
    end
    chk("rd_inflight", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    d0 = delivered;
    cycle();
    for (int i = 0; i < 30 && delivered == d0; i++) cycle();
    chk("rd_first_pc", 32'(last_pc), 32'h0040);

    // Wrap through 16'hFFFF
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    d0 = delivered;
    cycle();
    for (int i = 0; i < 40 && delivered < d0 + 4; i++) cycle();
    chk("wrap_pc4", 32'(last_pc), 32'h0001);

    // Grant stall: request and address held
    lat_min = 1; lat_max = 1;
    gnt_pct = 0;
    repeat (4) cycle();
    held = imem_addr;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",  32'(imem_req),  32'd1);
      chk("stall_addr", 32'(imem_addr), 32'(held));
      cycle();
    end

    // Halt with words in flight: no requests, in-flight data still delivered
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    repeat (2) cycle();
    halt = 1'b1;
    d0 = delivered;
    repeat (8) cycle();
    chk("halt_drain",   32'(delivered > d0), 32'd1);
    chk("halt_noinflt", 32'(mq.size()),      32'd0);
    halt = 1'b0;
    d0 = delivered;
    repeat (20) cycle();
    chk("halt_resume", 32'(delivered > d0), 32'd1);

    // Randomized traffic
    gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 4;
    d0 = delivered;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99, 0) < 3) begin
        redirect    = 1'b1;
        redirect_pc = 16'($urandom);
      end
      if ($urandom_range(99, 0) < 5) halt = ~halt;
      cycle();
    end
    chk("rand_volume", 32'(delivered > d0 + 200), 32'd1);

    // Spurious response while idle
    halt = 1'b1; gnt_pct = 0; rdy_pct = 100;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle();
      if (mq.size() == 0 && !inst_valid) ok = 1'b1;
    end
    chk("err_idle",   32'(ok),        32'd1);
    chk("err_before", 32'(fetch_err), 32'd0);
    spurious = 1'b1;
    cycle();
    chk("err_set",    32'(fetch_err),  32'd1);
    chk("err_nopush", 32'(inst_valid), 32'd0);
    repeat (3) cycle();
    chk("err_sticky", 32'(fetch_err), 32'd1);

    // Asynchronous reset mid-stream
    halt = 1'b0; gnt_pct = 100; lat_min = 1; lat_max = 2;
    repeat (10) cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    do_reset();
    d0 = delivered;
    repeat (15) cycle();
    chk("post_rst_stream", 32'(delivered >= d0 + 4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
